batcher_sort_pipe: RTL and testbench

- Parametrised, fully pipelined Batcher odd-even merge sorting network. It sorts NUM_ELEMS unsigned ELEM_WIDTH-bit elements per transaction, in ascending or descending order selected per transaction.
- Every network stage is registered. A valid/ready handshake on both sides gives one sort per cycle throughput, with backpressure.
- It succeeds the fixed 8x4-bit combinational sorter in the sort datapath.

---
 rtl/batcher_sort_pipe.sv | 118 +++++++++++
 tb/tb_batcher_sort_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batcher_sort_pipe.sv
// Pipelined Batcher odd-even merge sorter, one registered stage per layer.
// Ports: in_* valid/ready/mode/data upstream, out_* valid/ready/mode/data downstream.
module batcher_sort_pipe #(
  parameter int NUM_ELEMS  = 8,
  parameter int ELEM_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_descending,
  input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] in_flattenedData,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_descending,
  output logic [NUM_ELEMS*ELEM_WIDTH-1:0] out_flattenedData
);

  localparam int LOG2_ELEMS = $clog2(NUM_ELEMS);
  localparam int NUM_STAGES = LOG2_ELEMS * (LOG2_ELEMS + 1) / 2;
  localparam int DW         = NUM_ELEMS * ELEM_WIDTH;
  localparam int W          = ELEM_WIDTH;

  if (NUM_ELEMS < 2 || (NUM_ELEMS & (NUM_ELEMS - 1)) != 0) begin : g_bad_elems
    $error("NUM_ELEMS must be a power of two >= 2");
  end
  if (ELEM_WIDTH < 1 || ELEM_WIDTH > 32) begin : g_bad_width
    $error("ELEM_WIDTH must be in 1..32");
  end

  // True when index a is the low side of a compare-exchange in the
  // layer with merge block size p and comparator distance k.
  function automatic bit is_lo(input int p, input int k, input int a);
    int base;
    base = k % p;
    if (a < base) return 1'b0;
    if (((a - base) % (2 * k)) >= k) return 1'b0;
    if (a + k >= NUM_ELEMS) return 1'b0;
    return (a / (2 * p)) == ((a + k) / (2 * p));
  endfunction

  logic                  adv;
  logic [DW-1:0]         data_q [NUM_STAGES];
  logic [DW-1:0]         data_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] desc_q;
  logic [NUM_STAGES-1:0] vld_d;
  logic [NUM_STAGES-1:0] desc_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar lp = 0; lp < LOG2_ELEMS; lp++) begin : g_lvl
    for (genvar lk = 0; lk <= lp; lk++) begin : g_lyr
      localparam int S = lp * (lp + 1) / 2 + lk;
      localparam int P = 1 << lp;
      localparam int K = 1 << (lp - lk);

      logic [DW-1:0] cur;
      logic [DW-1:0] nxt;
      logic          cur_desc;
      logic          cur_vld;

      if (S == 0) begin : g_head
        assign cur      = in_flattenedData;
        assign cur_desc = in_descending;
        assign cur_vld  = in_valid && in_ready;
      end else begin : g_link
        assign cur      = data_q[S-1];
        assign cur_desc = desc_q[S-1];
        assign cur_vld  = vld_q[S-1];
      end

      for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_el
        localparam bit LO = is_lo(P, K, e);
        localparam bit HI = is_lo(P, K, e - K);
        if (LO) begin : g_lo
          logic [W-1:0] x, y;
          logic         sw;
          assign x  = cur[W*e +: W];
          assign y  = cur[W*(e+K) +: W];
          assign sw = cur_desc ? (x < y) : (x > y);
          assign nxt[W*e +: W] = sw ? y : x;
        end else if (HI) begin : g_hi
          logic [W-1:0] x, y;
          logic         sw;
          assign x  = cur[W*(e-K) +: W];
          assign y  = cur[W*e +: W];
          assign sw = cur_desc ? (x < y) : (x > y);
          assign nxt[W*e +: W] = sw ? x : y;
        end else begin : g_pass
          assign nxt[W*e +: W] = cur[W*e +: W];
        end
      end

      assign data_d[S] = nxt;
      assign desc_d[S] = cur_desc;
      assign vld_d[S]  = cur_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++) data_q[s] <= '0;
      vld_q  <= '0;
      desc_q <= '0;
    end else if (adv) begin
      for (int s = 0; s < NUM_STAGES; s++) data_q[s] <= data_d[s];
      vld_q  <= vld_d;
      desc_q <= desc_d;
    end
  end

  assign out_valid         = vld_q[NUM_STAGES-1];
  assign out_descending    = desc_q[NUM_STAGES-1];
  assign out_flattenedData = data_q[NUM_STAGES-1];

endmodule

// File: tb/tb_batcher_sort_pipe.sv
// Self-checking bench for batcher_sort_pipe (8x4 default and 16x8 instance).
// Directed table vectors, streams against a sorting model, stalls and reset.
`timescale 1ns/1ps
module tb_batcher_sort_pipe;
  localparam int N   = 8;
  localparam int W   = 4;
  localparam int NS  = 6;
  localparam int DW  = N * W;
  localparam int N2  = 16;
  localparam int W2  = 8;
  localparam int NS2 = 10;
  localparam int DW2 = N2 * W2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_in_valid, a_in_ready, a_in_desc;
  logic [DW-1:0] a_in_data;
  logic          a_out_valid, a_out_ready, a_out_desc;
  logic [DW-1:0] a_out_data;

  logic           b_in_valid, b_in_ready, b_in_desc;
  logic [DW2-1:0] b_in_data;
  logic           b_out_valid, b_out_ready, b_out_desc;
  logic [DW2-1:0] b_out_data;

  batcher_sort_pipe #(.NUM_ELEMS(N), .ELEM_WIDTH(W)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_descending(a_in_desc), .in_flattenedData(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_descending(a_out_desc), .out_flattenedData(a_out_data)
  );

  batcher_sort_pipe #(.NUM_ELEMS(N2), .ELEM_WIDTH(W2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_descending(b_in_desc), .in_flattenedData(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_descending(b_out_desc), .out_flattenedData(b_out_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_sort(input logic [127:0] d,
      input int n, input int w, input bit desc);
    int unsigned v[16];
    int unsigned t;
    int j;
    logic [127:0] r;
    for (int i = 0; i < n; i++)
      v[i] = int'((d >> (w * i)) & ((128'd1 << w) - 1));
    for (int i = 1; i < n; i++) begin
      t = v[i];
      j = i - 1;
      while (j >= 0 && v[j] > t) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = t;
    end
    r = '0;
    for (int i = 0; i < n; i++)
      r |= 128'(desc ? v[n-1-i] : v[i]) << (w * i);
    return r;
  endfunction

  logic [128:0]  qa[$];
  logic [128:0]  qb[$];
  bit            mon_a = 1'b0;
  bit            mon_b = 1'b0;
  int            pops_a = 0;
  int            pops_b = 0;
  logic          a_prev_stall = 1'b0;
  logic [DW-1:0] a_prev_data = '0;
  logic          a_prev_desc = 1'b0;

  always @(negedge clk) begin : mon_a_blk
    logic [128:0] e;
    if (mon_a) begin
      chk("a_in_ready", 128'(a_in_ready), 128'(!a_out_valid || a_out_ready));
      if (a_prev_stall) begin
        chk("a_hold_valid", 128'(a_out_valid), 128'd1);
        chk("a_hold_data", 128'(a_out_data), 128'(a_prev_data));
        chk("a_hold_desc", 128'(a_out_desc), 128'(a_prev_desc));
      end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_extra_out: got %0h expected none", a_out_data);
        end else begin
          e = qa.pop_front();
          pops_a++;
          chk("a_data", 128'(a_out_data), 128'(e[DW-1:0]));
          chk("a_desc", 128'(a_out_desc), 128'(e[128]));
        end
      end
      if (a_in_valid && a_in_ready)
        qa.push_back({a_in_desc, ref_sort(128'(a_in_data), N, W, a_in_desc)});
    end
    a_prev_stall <= mon_a && a_out_valid && !a_out_ready;
    a_prev_data  <= a_out_data;
    a_prev_desc  <= a_out_desc;
  end

  always @(negedge clk) begin : mon_b_blk
    logic [128:0] e;
    if (mon_b) begin
      chk("b_in_ready", 128'(b_in_ready), 128'(!b_out_valid || b_out_ready));
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_extra_out: got %0h expected none", b_out_data);
        end else begin
          e = qb.pop_front();
          pops_b++;
          chk("b_data", b_out_data, e[127:0]);
          chk("b_desc", 128'(b_out_desc), 128'(e[128]));
        end
      end
      if (b_in_valid && b_in_ready)
        qb.push_back({b_in_desc, ref_sort(b_in_data, N2, W2, b_in_desc)});
    end
  end

  task automatic send_a(input bit desc, input logic [DW-1:0] d);
    bit acc;
    int n;
    a_in_valid = 1'b1;
    a_in_desc  = desc;
    a_in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    a_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL a_send_timeout: got no accept expected accept");
    end
  endtask

  task automatic send_b(input bit desc, input logic [DW2-1:0] d);
    bit acc;
    int n;
    b_in_valid = 1'b1;
    b_in_desc  = desc;
    b_in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    b_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL b_send_timeout: got no accept expected accept");
    end
  endtask

  task automatic shot_a(input string nm, input bit desc,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp);
    a_in_valid = 1'b1;
    a_in_desc  = desc;
    a_in_data  = d;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (NS - 2) @(posedge clk);
    #1;
    chk({nm, "_early"}, 128'(a_out_valid), 128'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 128'(a_out_valid), 128'd1);
    chk({nm, "_data"}, 128'(a_out_data), 128'(exp));
    chk({nm, "_desc"}, 128'(a_out_desc), 128'(desc));
    @(posedge clk);
    #1;
    chk({nm, "_once"}, 128'(a_out_valid), 128'd0);
  endtask

  task automatic shot_b(input string nm, input bit desc,
                        input logic [DW2-1:0] d, input logic [DW2-1:0] exp);
    b_in_valid = 1'b1;
    b_in_desc  = desc;
    b_in_data  = d;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (NS2 - 2) @(posedge clk);
    #1;
    chk({nm, "_early"}, 128'(b_out_valid), 128'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 128'(b_out_valid), 128'd1);
    chk({nm, "_data"}, b_out_data, exp);
    chk({nm, "_desc"}, 128'(b_out_desc), 128'(desc));
    @(posedge clk);
    #1;
    chk({nm, "_once"}, 128'(b_out_valid), 128'd0);
  endtask

  typedef struct {
    string         nm;
    bit            desc;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    tbl[0] = '{"asc_basic", 1'b0, 32'h24061537, 32'h76543210};
    tbl[1] = '{"desc_dups", 1'b1, 32'h041F0F44, 32'h001444FF};
    tbl[2] = '{"asc_zero",  1'b0, 32'h00000000, 32'h00000000};
    tbl[3] = '{"asc_max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[4] = '{"desc_rev",  1'b1, 32'h76543210, 32'h01234567};
    tbl[5] = '{"asc_rev",   1'b0, 32'h01234567, 32'h76543210};
    tbl[6] = '{"asc_ext",   1'b0, 32'hE1880F0F, 32'hFFE88100};
    tbl[7] = '{"desc_ext",  1'b1, 32'hE1880F0F, 32'h00188EFF};

    rst_n = 1'b1;
    a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_valid", 128'(a_out_valid), 128'd0);
    chk("rst_a_data", 128'(a_out_data), 128'd0);
    chk("rst_a_desc", 128'(a_out_desc), 128'd0);
    chk("rst_b_valid", 128'(b_out_valid), 128'd0);
    chk("rst_b_data", b_out_data, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 128'(a_in_ready), 128'd1);
    chk("rel_valid", 128'(a_out_valid), 128'd0);

    a_out_ready = 1'b1;
    mon_a = 1'b1;
    for (int i = 0; i < 8; i++)
      shot_a(tbl[i].nm, tbl[i].desc, tbl[i].din, tbl[i].exp);

    p0 = pops_a;
    for (int i = 0; i < 20; i++) send_a(i[0], $urandom);
    repeat (NS + 2) @(posedge clk);
    #1;
    chk("mixed_count", 128'(pops_a - p0), 128'd20);
    chk("mixed_empty", 128'(qa.size()), 128'd0);

    p0 = pops_a;
    fork
      begin
        for (int i = 0; i < 10; i++) send_a(1'($urandom), $urandom);
      end
      begin
        a_out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int c = 0; c < 30; c++) begin
          a_out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    a_out_ready = 1'b1;
    repeat (NS + 4) @(posedge clk);
    #1;
    chk("bp_count", 128'(pops_a - p0), 128'd10);
    chk("bp_empty", 128'(qa.size()), 128'd0);
    mon_a = 1'b0;

    b_out_ready = 1'b1;
    mon_b = 1'b1;
    shot_b("b_zero_asc", 1'b0, 128'hFFFFFFFFFFFFFFFFFFFF00FFFFFFFFFF,
           128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00);
    shot_b("b_zero_desc", 1'b1, 128'hFFFFFFFFFFFFFFFFFFFF00FFFFFFFFFF,
           128'h00FFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
    p0 = pops_b;
    for (int i = 0; i < 1000; i++)
      send_b(1'($urandom), {$urandom, $urandom, $urandom, $urandom});
    repeat (NS2 + 2) @(posedge clk);
    #1;
    chk("b_rand_count", 128'(pops_b - p0), 128'd1000);
    chk("b_rand_empty", 128'(qb.size()), 128'd0);
    mon_b = 1'b0;

    a_out_ready = 1'b0;
    send_a(1'b0, 32'h24061537);
    send_a(1'b1, 32'h041F0F44);
    send_a(1'b0, 32'h01234567);
    send_a(1'b1, 32'h76543210);
    repeat (8) @(posedge clk);
    #3;
    chk("mid_pre_valid", 128'(a_out_valid), 128'd1);
    chk("mid_pre_data", 128'(a_out_data), 128'h76543210);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(a_out_valid), 128'd0);
    chk("mid_rst_data", 128'(a_out_data), 128'd0);
    chk("mid_rst_desc", 128'(a_out_desc), 128'd0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 128'(a_out_valid), 128'd0);
    end
    shot_a("post_rst", 1'b0, 32'hE1880F0F, 32'hFFE88100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
